// File: rtl/microc_pkg.sv
// Shared definitions for the microc_stack core: ALU op encoding, stack
// occupancy states, instruction field offsets and parameter legality.
package microc_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'b000,
    ALU_NOT_A  = 3'b001,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_NEG_A  = 3'b110,
    ALU_NEG_B  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    STK_EMPTY   = 2'b00,
    STK_PARTIAL = 2'b01,
    STK_FULL    = 2'b10
  } stk_state_e;

  localparam int unsigned OPC_W      = 6;
  localparam int unsigned RA1_LSB    = 0;
  localparam int unsigned TARGET_LSB = 0;

  function automatic int unsigned ra2_lsb(input int unsigned raw);
    return raw;
  endfunction

  function automatic int unsigned wa3_lsb(input int unsigned raw);
    return 2 * raw;
  endfunction

  function automatic int unsigned inm_lsb(input int unsigned raw);
    return raw;
  endfunction

  function automatic int unsigned opc_lsb(input int unsigned iw);
    return iw - OPC_W;
  endfunction

  // True when the field layout fits the instruction word without overlap.
  function automatic bit params_legal(input int unsigned iw, input int unsigned dw,
                                      input int unsigned pcw, input int unsigned nreg,
                                      input int unsigned sdepth);
    int unsigned raw;
    raw = $clog2(nreg);
    return (nreg >= 2) && ((1 << raw) == nreg) &&
           (iw >= 3 * raw + OPC_W) && (iw >= dw + raw) &&
           (iw >= pcw + OPC_W) && (sdepth >= 2);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: push/pop of PCW-bit addresses, SDEPTH entries deep.
// Entry contents are not reset; only the stack pointer is.
module ret_stack
  import microc_pkg::*;
#(
  parameter int unsigned PCW    = 10,
  parameter int unsigned SDEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] din,
  output logic [PCW-1:0] top,
  output logic           full,
  output logic           empty
);

  localparam int unsigned SPW = $clog2(SDEPTH + 1);
  localparam int unsigned AW  = $clog2(SDEPTH);

  logic [PCW-1:0] mem [SDEPTH];
  logic [SPW-1:0] sp;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;
  stk_state_e     state;

  assign wr_idx = sp[AW-1:0];
  assign rd_idx = AW'(sp - SPW'(1));
  assign top    = mem[rd_idx];
  assign full   = (state == STK_FULL);
  assign empty  = (state == STK_EMPTY);

  // Stack pointer: increments on an accepted push, decrements on an accepted pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SPW'(1);
    end
  end

  // Entry storage, written at the slot above the current top.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

  // Occupancy state decoded from the stack pointer.
  always_comb begin
    state = STK_PARTIAL;
    if (sp == '0) begin
      state = STK_EMPTY;
    end else if (sp == SPW'(SDEPTH)) begin
      state = STK_FULL;
    end
  end

endmodule

// File: rtl/microc_stack.sv
// Microcontroller datapath: register file, ALU, zero flag and program
// counter with call/return via the ret_stack sub-module.
module microc_stack
  import microc_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned PCW    = 10,
  parameter int unsigned NREG   = 16,
  parameter int unsigned IW     = 16,
  parameter int unsigned SDEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [IW-1:0]  instr,
  output logic [PCW-1:0] pc,
  output logic [5:0]     opcode,
  input  logic           s_inc,
  input  logic           s_skip,
  input  logic           s_inm,
  input  logic           we3,
  input  logic           wez,
  input  logic [2:0]     op,
  input  logic           s_call,
  input  logic           s_ret,
  output logic           z,
  output logic           stk_ovf,
  output logic           stk_unf
);

  localparam int unsigned RAW       = $clog2(NREG);
  localparam int unsigned RA2_LSB   = ra2_lsb(RAW);
  localparam int unsigned WA3_LSB   = wa3_lsb(RAW);
  localparam int unsigned INM_LSB   = inm_lsb(RAW);
  localparam int unsigned OPC_LSB   = opc_lsb(IW);
  localparam bit          PARAMS_OK = params_legal(IW, DW, PCW, NREG, SDEPTH);

  logic [RAW-1:0] ra1, ra2, wa3;
  logic [DW-1:0]  inm, rd1, rd2, alu_out, wd3;
  logic [PCW-1:0] target, pc_next, pc_inc1, pc_inc2, stk_top;
  logic [DW-1:0]  regs [NREG];
  logic           do_call, do_ret, push, pop, stk_full, stk_empty;

  assign ra1    = instr[RA1_LSB +: RAW];
  assign ra2    = instr[RA2_LSB +: RAW];
  assign wa3    = instr[WA3_LSB +: RAW];
  assign inm    = instr[INM_LSB +: DW];
  assign target = instr[TARGET_LSB +: PCW];
  assign opcode = instr[OPC_LSB +: OPC_W];

  // Flags an illegal parameter set; with NREG=16 the opcode needs IW >= 18 to stay clear of wa3.
  always_comb begin : chk_params
    assert (PARAMS_OK) else $error("microc_stack: IW too narrow for field layout");
  end

  // Combinational register reads; r0 is hardwired to zero.
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : regs[ra1];
    rd2 = (ra2 == '0) ? '0 : regs[ra2];
  end

  // ALU, results wrap at DW bits.
  always_comb begin
    alu_out = rd1;
    unique case (alu_op_e'(op))
      ALU_PASS_A: alu_out = rd1;
      ALU_NOT_A:  alu_out = ~rd1;
      ALU_ADD:    alu_out = rd1 + rd2;
      ALU_SUB:    alu_out = rd1 - rd2;
      ALU_AND:    alu_out = rd1 & rd2;
      ALU_OR:     alu_out = rd1 | rd2;
      ALU_NEG_A:  alu_out = -rd1;
      ALU_NEG_B:  alu_out = -rd2;
      default:    alu_out = rd1;
    endcase
  end

  assign wd3 = s_inm ? inm : alu_out;

  // Register file write; writes to r0 are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (en && we3 && (wa3 != '0)) begin
      regs[wa3] <= wd3;
    end
  end

  // Zero flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z <= 1'b0;
    end else if (en && wez) begin
      z <= (alu_out == '0);
    end
  end

  // Return wins over call when both are requested.
  assign do_ret  = s_ret;
  assign do_call = s_call && !s_ret;
  assign push    = en && do_call && !stk_full;
  assign pop     = en && do_ret && !stk_empty;
  assign pc_inc1 = pc + PCW'(1);
  assign pc_inc2 = pc + PCW'(2);

  // Next-PC selection: return, call, jump, then sequential.
  always_comb begin
    pc_next = s_skip ? pc_inc2 : pc_inc1;
    if (do_ret) begin
      pc_next = stk_empty ? pc_inc1 : stk_top;
    end else if (do_call || !s_inc) begin
      pc_next = target;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (en) begin
      pc <= pc_next;
    end
  end

  // Sticky stack error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (en) begin
      if (do_call && stk_full) stk_ovf <= 1'b1;
      if (do_ret && stk_empty) stk_unf <= 1'b1;
    end
  end

  ret_stack #(
    .PCW    (PCW),
    .SDEPTH (SDEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc1),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

endmodule
